// File: rtl/vin_add_sequencer.sv
// Time-multiplexed N_IN-operand signed fixed-point adder: one operand per cycle through a shared accumulator.
// Optional build macro VIN_ADD_SAT_EN makes every accumulation step saturate instead of wrap.
module vin_add_sequencer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FRACT_WIDTH = 8,
    parameter int unsigned N_IN        = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN*DATA_WIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_ovf,
    output logic                       busy
);

    localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned MSB   = DATA_WIDTH - 1;

    // Elaboration-time parameter legality
    generate
        if (N_IN < 2 || N_IN > 256) begin : g_bad_n_in
            $error("vin_add_sequencer: N_IN must be within 2..256");
        end
        if (FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
            $error("vin_add_sequencer: FRACT_WIDTH must be below DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_WIDTH-1:0]  r_ops [N_IN];
    logic [DATA_WIDTH-1:0]  w_ops_nxt [N_IN];
    logic [DATA_WIDTH-1:0]  r_acc;
    logic [DATA_WIDTH-1:0]  w_acc_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic                   r_ovf;
    logic                   w_ovf_nxt;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic [DATA_WIDTH-1:0]  w_out_data_nxt;
    logic                   r_out_ovf;
    logic                   w_out_ovf_nxt;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_busy;

    logic [DATA_WIDTH-1:0]  w_op;
    logic [DATA_WIDTH-1:0]  w_sum;
    logic [DATA_WIDTH-1:0]  w_step;
    logic                   w_step_ovf;

    // One accumulation step: overflow when equal-sign operands yield a sign flip
    assign w_op       = r_ops[r_idx];
    assign w_sum      = r_acc + w_op;
    assign w_step_ovf = (r_acc[MSB] == w_op[MSB]) && (w_sum[MSB] != r_acc[MSB]);

`ifdef VIN_ADD_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    assign w_step = w_step_ovf ? (w_op[MSB] ? SAT_MIN : SAT_MAX) : w_sum;
`else
    assign w_step = w_sum;
`endif

    // Next-state and datapath update
    always_comb begin
        w_state_nxt    = r_state;
        w_ops_nxt      = r_ops;
        w_acc_nxt      = r_acc;
        w_idx_nxt      = r_idx;
        w_ovf_nxt      = r_ovf;
        w_out_data_nxt = r_out_data;
        w_out_ovf_nxt  = r_out_ovf;

        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    for (int k = 0; k < int'(N_IN); k++) begin
                        w_ops_nxt[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                    w_acc_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                w_acc_nxt = w_step;
                w_ovf_nxt = r_ovf | w_step_ovf;
                w_idx_nxt = r_idx + IDX_W'(1);
                if (r_idx == IDX_W'(N_IN - 1)) begin
                    w_out_data_nxt = w_step;
                    w_out_ovf_nxt  = r_ovf | w_step_ovf;
                    w_state_nxt    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; status outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            for (int k = 0; k < int'(N_IN); k++) begin
                r_ops[k] <= '0;
            end
            r_acc       <= '0;
            r_idx       <= '0;
            r_ovf       <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ops       <= w_ops_nxt;
            r_acc       <= w_acc_nxt;
            r_idx       <= w_idx_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_ovf   <= w_out_ovf_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_vin_add_sequencer.sv
// Self-checking bench for vin_add_sequencer (defaults 16/8/3) against an integer-arithmetic reference model.
module tb_vin_add_sequencer;

    localparam int DW = 16;
    localparam int N  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_ovf;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vin_add_sequencer #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .N_IN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // Reference: plain integer sums with range test, then wrap or clamp per step
    function automatic void model(input logic [N*DW-1:0] v, output logic [DW-1:0] sum, output logic ovf);
        int acc;
        int s;
        int op;
        logic [DW-1:0] part;
        acc = 0;
        ovf = 1'b0;
        for (int k = 0; k < N; k++) begin
            part = v[k*DW +: DW];
            op   = int'($signed(part));
            s    = acc + op;
            if (s > 32767 || s < -32768) begin
                ovf = 1'b1;
`ifdef VIN_ADD_SAT_EN
                s = (s > 32767) ? 32767 : -32768;
`else
                s = (s > 32767) ? s - 65536 : s + 65536;
`endif
            end
            acc = s;
        end
        sum = DW'(acc);
    endfunction

    // Stimulus helper: one full transaction, reports result and latency in cycles
    task automatic do_txn(input logic [N*DW-1:0] vec, output logic [DW-1:0] data,
                          output logic ovf, output int lat, output bit ok);
        bit hs;
        int t;
        hs   = 0;
        ok   = 0;
        lat  = -1;
        data = '0;
        ovf  = 1'b0;
        @(negedge clk);
        in_data   = vec;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        t = 0;
        while (!hs && t < 40) begin
            if (in_ready) hs = 1;
            else begin
                @(negedge clk);
                t++;
            end
        end
        if (!hs) begin
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!ok && t < 40) begin
            if (out_valid) begin
                data = out_data;
                ovf  = out_ovf;
                lat  = t;
                ok   = 1;
            end else begin
                @(negedge clk);
                t++;
            end
        end
        if (ok) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000 ||
            out_ovf !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h out_ovf=%b busy=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, out_data, out_ovf, busy);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] d;
        logic o;
        int lat;
        bit ok;
        do_txn({16'hFF00, 16'h0200, 16'h0100}, d, o, lat, ok);
        checks++;
        if (!ok || d !== 16'h0200 || o !== 1'b0 || lat !== 3) begin
            errors++;
            $display("FAIL basic: ok=%0d data=%h ovf=%b lat=%0d, want ok=1 data=0200 ovf=0 lat=3", ok, d, o, lat);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] d;
        logic o;
        int lat;
        bit ok;
        logic [DW-1:0] exp_pos;
        logic [DW-1:0] exp_neg;
`ifdef VIN_ADD_SAT_EN
        exp_pos = 16'h7FFF;
        exp_neg = 16'h8100;
`else
        exp_pos = 16'hE100;
        exp_neg = 16'h8000;
`endif
        do_txn({16'h0100, 16'h7000, 16'h7000}, d, o, lat, ok);
        checks++;
        if (!ok || d !== exp_pos || o !== 1'b1) begin
            errors++;
            $display("FAIL pos_overflow: ok=%0d data=%h ovf=%b, want data=%h ovf=1", ok, d, o, exp_pos);
        end
        do_txn({16'h0100, 16'hFF00, 16'h8000}, d, o, lat, ok);
        checks++;
        if (!ok || d !== exp_neg || o !== 1'b1) begin
            errors++;
            $display("FAIL neg_overflow: ok=%0d data=%h ovf=%b, want data=%h ovf=1", ok, d, o, exp_neg);
        end
    endtask

    task automatic test_random();
        logic [N*DW-1:0] v;
        logic [DW-1:0] d;
        logic [DW-1:0] ed;
        logic o;
        logic eo;
        int lat;
        bit ok;
        logic [DW-1:0] r;
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 2))
                    0: r = DW'($urandom);
                    1: r = DW'($urandom_range(0, 255)) - DW'(128);
                    default: r = $urandom_range(0, 1) != 0 ? 16'h7F00 | DW'($urandom_range(0, 255))
                                                           : 16'h8000 | DW'($urandom_range(0, 255));
                endcase
                v[k*DW +: DW] = r;
            end
            model(v, ed, eo);
            do_txn(v, d, o, lat, ok);
            checks++;
            if (!ok || d !== ed || o !== eo || lat !== N) begin
                errors++;
                $display("FAIL random[%0d]: vec=%h ok=%0d data=%h ovf=%b lat=%0d, want data=%h ovf=%b lat=%0d",
                         n, v, ok, d, o, lat, ed, eo, N);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N*DW-1:0] va;
        logic [N*DW-1:0] vb;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic oa;
        logic ob;
        int t;
        int bad;
        va = {16'h0300, 16'hFE00, 16'h1234};
        vb = {16'h0011, 16'h0022, 16'h0033};
        model(va, ea, oa);
        model(vb, eb, ob);
        @(negedge clk);
        in_data   = va;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        in_data = vb;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b1 || out_data !== ea || out_ovf !== oa || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d bad cycles, last out_valid=%b data=%h in_ready=%b, want 1 %h 0",
                     bad, out_valid, out_data, in_ready, ea);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_capture: busy=%b in_ready=%b, want 1 0", busy, in_ready);
        end
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== eb || out_ovf !== ob) begin
            errors++;
            $display("FAIL backpressure_second: out_valid=%b data=%h ovf=%b, want 1 %h %b",
                     out_valid, out_data, out_ovf, eb, ob);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        logic o;
        int lat;
        bit ok;
        int seen;
        int t;
        @(negedge clk);
        in_data  = {16'h0555, 16'h0777, 16'h1234};
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_emit: out_valid seen %0d cycles, want 0", seen);
        end
        do_txn({16'h0001, 16'h0001, 16'h0001}, d, o, lat, ok);
        checks++;
        if (!ok || d !== 16'h0003 || o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_residue: ok=%0d data=%h ovf=%b, want data=0003 ovf=0", ok, d, o);
        end
    endtask

    task automatic test_back_to_back();
        logic [N*DW-1:0] vecs [4];
        logic [DW-1:0] ed [4];
        logic eo [4];
        int n_in;
        int n_out;
        int last;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N; k++) vecs[i][k*DW +: DW] = DW'($urandom);
            model(vecs[i], ed[i], eo[i]);
        end
        n_in  = 0;
        n_out = 0;
        last  = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int c = 0; c < 80 && n_out < 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (out_data !== ed[n_out] || out_ovf !== eo[n_out]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: data=%h ovf=%b, want %h %b",
                             n_out, out_data, out_ovf, ed[n_out], eo[n_out]);
                end
                if (n_out > 0) begin
                    checks++;
                    if (c - last != N + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d]: gap=%0d, want %0d", n_out, c - last, N + 2);
                    end
                end
                last = c;
                n_out++;
            end
            if (in_ready) begin
                if (n_in < 4) begin
                    in_data  = vecs[n_in];
                    in_valid = 1'b1;
                    n_in++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checks++;
        if (n_out != 4) begin
            errors++;
            $display("FAIL b2b_count: results=%0d, want 4", n_out);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
